freq_channel_scheduler: RTL and testbench

//  Time-shares one square-wave period detector (COUNTER_WIDTH-bit period, stable flag) among
//  NUM_CH comparator channels. Round-robins over enabled channels: drives the channel mux,

---
 rtl/freq_channel_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_freq_channel_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_channel_scheduler.sv
// Round-robin scheduler that time-shares one period detector across NUM_CH comparator channels
// and hands each (channel, period, timeout) result downstream over a valid/ready port.
module freq_channel_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int COUNTER_WIDTH  = 18,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [NUM_CH-1:0]         ch_enable,
  output logic [$clog2(NUM_CH)-1:0] mux_sel,
  output logic                      det_clear,
  input  logic [COUNTER_WIDTH-1:0]  det_period,
  input  logic                      det_stable,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NUM_CH)-1:0] res_ch,
  output logic [COUNTER_WIDTH-1:0]  res_period,
  output logic                      res_timeout,
  output logic                      busy
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int ST_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = (TO_W > ST_W) ? TO_W : ST_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    MEASURE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     stable_prev_q, stable_prev_d;
  logic [CH_W-1:0]          last_ch_q, last_ch_d;
  logic [CH_W-1:0]          mux_sel_q, mux_sel_d;
  logic                     det_clear_q, det_clear_d;
  logic                     res_valid_q, res_valid_d;
  logic [CH_W-1:0]          res_ch_q, res_ch_d;
  logic [COUNTER_WIDTH-1:0] res_period_q, res_period_d;
  logic                     res_timeout_q, res_timeout_d;
  logic                     busy_q, busy_d;

  logic [CH_W-1:0] base_ch;
  logic [CH_W-1:0] next_ch;
  logic            any_en;
  logic            capture;

  assign any_en  = |ch_enable;
  // While in OUTPUT, mux_sel is the channel about to become last_ch.
  assign base_ch = (state_q == OUTPUT) ? mux_sel_q : last_ch_q;

  // Rotating priority search: scan downward so the nearest enabled channel after base wins.
  always_comb begin
    next_ch = base_ch;
    for (int i = NUM_CH; i >= 1; i--) begin
      int cand;
      cand = int'(base_ch) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (ch_enable[CH_W'(cand)]) next_ch = CH_W'(cand);
    end
  end

  assign capture = (cnt_q != '0) && det_stable && stable_prev_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stable_prev_d = 1'b0;
    last_ch_d     = last_ch_q;
    mux_sel_d     = mux_sel_q;
    det_clear_d   = det_clear_q;
    res_valid_d   = res_valid_q;
    res_ch_d      = res_ch_q;
    res_period_d  = res_period_q;
    res_timeout_d = res_timeout_q;
    busy_d        = busy_q;

    case (state_q)
      IDLE: begin
        det_clear_d = 1'b1;
        if (run && any_en) begin
          mux_sel_d = next_ch;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SELECT;
        end
      end

      SELECT: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          det_clear_d = 1'b0;
          cnt_d       = '0;
          state_d     = MEASURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      MEASURE: begin
        // First MEASURE cycle never counts toward the two-in-a-row stable run.
        stable_prev_d = (cnt_q != '0) && det_stable;
        if (capture) begin
          res_period_d  = det_period;
          res_timeout_d = 1'b0;
          res_ch_d      = mux_sel_q;
          res_valid_d   = 1'b1;
          det_clear_d   = 1'b1;
          state_d       = OUTPUT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          res_period_d  = '0;
          res_timeout_d = 1'b1;
          res_ch_d      = mux_sel_q;
          res_valid_d   = 1'b1;
          det_clear_d   = 1'b1;
          state_d       = OUTPUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      OUTPUT: begin
        det_clear_d = 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
          last_ch_d   = mux_sel_q;
          if (run && any_en) begin
            mux_sel_d = next_ch;
            cnt_d     = '0;
            state_d   = SELECT;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stable_prev_q <= 1'b0;
      last_ch_q     <= CH_W'(NUM_CH - 1);
      mux_sel_q     <= '0;
      det_clear_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_period_q  <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stable_prev_q <= stable_prev_d;
      last_ch_q     <= last_ch_d;
      mux_sel_q     <= mux_sel_d;
      det_clear_q   <= det_clear_d;
      res_valid_q   <= res_valid_d;
      res_ch_q      <= res_ch_d;
      res_period_q  <= res_period_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign mux_sel     = mux_sel_q;
  assign det_clear   = det_clear_q;
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_period  = res_period_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_freq_channel_scheduler.sv
// Bench for freq_channel_scheduler: emulated period detector per channel, a result model derived
// from the detector waveform, and a per-cycle checker on the negative clock edge.
module tb_freq_channel_scheduler;

  localparam int NCH    = 4;
  localparam int CW     = 18;
  localparam int SETTLE = 4;
  localparam int TMO    = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [NCH-1:0] ch_enable;
  logic [1:0]    mux_sel;
  logic          det_clear;
  logic [CW-1:0] det_period;
  logic          det_stable;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_ch;
  logic [CW-1:0] res_period;
  logic          res_timeout;
  logic          busy;

  freq_channel_scheduler #(
    .NUM_CH(NCH), .COUNTER_WIDTH(CW), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .ch_enable(ch_enable), .mux_sel(mux_sel),
    .det_clear(det_clear), .det_period(det_period), .det_stable(det_stable),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_period(res_period), .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Emulated detector: kc counts cycles since det_clear released; per-channel behaviour is configurable.
  int cfg_period[NCH];
  int cfg_delay[NCH];
  int cfg_glitch[NCH];
  bit cfg_low[NCH];
  int kc;

  always @(posedge clk) begin
    if (det_clear) kc <= 0;
    else           kc <= kc + 1;
  end

  always_comb begin
    det_stable = !det_clear && !cfg_low[mux_sel] &&
                 ((kc >= cfg_delay[mux_sel]) || (kc == cfg_glitch[mux_sel]));
    det_period = det_clear ? '0 : CW'(cfg_period[mux_sel] + kc);
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit stab(input int ch, input int k);
    return !cfg_low[ch] && ((k >= cfg_delay[ch]) || (k == cfg_glitch[ch]));
  endfunction

  // Expected result for a visit: scan the detector waveform for two consecutive stable cycles,
  // ignoring cycle 0; latency is counted from the first MEASURE cycle to res_valid.
  task automatic model_result(input int ch, output int per, output int to, output int lat);
    per = 0; to = 1; lat = TMO;
    for (int k = 2; k <= TMO - 1; k++) begin
      if (stab(ch, k) && stab(ch, k - 1)) begin
        per = cfg_period[ch] + k; to = 0; lat = k + 1;
        break;
      end
    end
  endtask

  function automatic int rotate(input int last, input logic [NCH-1:0] mask);
    for (int i = 1; i <= NCH; i++) begin
      int c;
      c = (last + i) % NCH;
      if (mask[c]) return c;
    end
    return last;
  endfunction

  // Per-cycle checker
  int  cyc = 0;
  int  model_last = NCH - 1;
  int  hs_count = 0;
  int  last_res_ch = -1;
  int  sel_start, meas_start, rise_cyc;
  int  exp_ch, exp_per, exp_to, exp_lat;
  bit  meas_ok = 0;
  bit  prev_busy = 0, prev_valid = 0, prev_clear = 1, prev_ready = 0;
  logic [1:0]    prev_ch, prev_mux;
  logic [CW-1:0] prev_per;
  logic          prev_to;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      model_last = NCH - 1;
      prev_busy = 0; prev_valid = 0; prev_clear = 1; prev_ready = 0;
      meas_ok = 0;
    end else begin
      if ((busy && !prev_busy) || (prev_valid && !res_valid && busy)) sel_start = cyc;
      if (prev_clear && !det_clear) begin
        exp_ch = rotate(model_last, ch_enable);
        chk("meas_ch", mux_sel, exp_ch);
        chk("settle_len", cyc - sel_start, SETTLE);
        model_result(exp_ch, exp_per, exp_to, exp_lat);
        meas_start = cyc;
        meas_ok = 1;
      end
      if (res_valid && !prev_valid) rise_cyc = cyc;
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_ch", res_ch, prev_ch);
        chk("hold_period", res_period, prev_per);
        chk("hold_timeout", res_timeout, prev_to);
        chk("hold_mux", mux_sel, prev_mux);
      end
      if (busy) chk("mux_enabled", ch_enable[mux_sel], 1);
      else begin
        chk("idle_clear", det_clear, 1);
        chk("idle_valid", res_valid, 0);
      end
      if (res_valid && res_ready) begin
        if (!meas_ok) chk("result_without_measure", 0, 1);
        else begin
          chk("res_ch", res_ch, exp_ch);
          chk("res_period", res_period, exp_per);
          chk("res_timeout", res_timeout, exp_to);
          chk("latency", rise_cyc - meas_start, exp_lat);
        end
        $display("result #%0d: ch=%0d period=%0d timeout=%0d", hs_count, res_ch, res_period, res_timeout);
        model_last = exp_ch;
        last_res_ch = res_ch;
        hs_count++;
        meas_ok = 0;
      end
      prev_busy = busy; prev_valid = res_valid; prev_clear = det_clear; prev_ready = res_ready;
      prev_ch = res_ch; prev_mux = mux_sel; prev_per = res_period; prev_to = res_timeout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int n, input int budget);
    int tgt;
    tgt = hs_count + n;
    while (hs_count < tgt && budget > 0) begin tick(); budget--; end
    if (hs_count < tgt) chk("wait_results_budget", hs_count, tgt);
  endtask

  task automatic wait_idle(input int budget);
    while (busy && budget > 0) begin tick(); budget--; end
    if (busy) chk("wait_idle_budget", busy, 0);
  endtask

  task automatic wait_meas(input int ch, input int budget);
    while (!(busy && !det_clear && (ch < 0 || int'(mux_sel) == ch)) && budget > 0) begin
      tick(); budget--;
    end
    if (!(busy && !det_clear)) chk("wait_measure_budget", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mux_sel"}, mux_sel, 0);
    chk({tag, "_det_clear"}, det_clear, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_ch"}, res_ch, 0);
    chk({tag, "_res_period"}, res_period, 0);
    chk({tag, "_res_timeout"}, res_timeout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic default_cfg();
    cfg_period = '{200, 400, 2000, 200000};
    cfg_delay  = '{5, 0, 20, 40};
    cfg_glitch = '{-1, -1, 3, -1};
    cfg_low    = '{0, 0, 0, 0};
  endtask

  initial begin
    int p, t, l;
    rst = 1'b1; run = 1'b0; ch_enable = '0; res_ready = 1'b1;
    default_cfg();

    // Pin the model with hand-computed values.
    model_result(0, p, t, l);
    chk("model_ch0_period", p, 206); chk("model_ch0_lat", l, 7);
    model_result(1, p, t, l);
    chk("model_ch1_period", p, 402); chk("model_ch1_lat", l, 3);
    model_result(2, p, t, l);
    chk("model_ch2_period", p, 2021); chk("model_ch2_lat", l, 22);
    model_result(3, p, t, l);
    chk("model_ch3_period", p, 200041); chk("model_ch3_timeout", t, 0);
    cfg_low[1] = 1;
    model_result(1, p, t, l);
    chk("model_low_period", p, 0); chk("model_low_timeout", t, 1); chk("model_low_lat", l, TMO);
    cfg_low[1] = 0;

    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Full scan, all channels, wrap to ch0
    ch_enable = 4'b1111; run = 1'b1;
    wait_hs(5, 2000);
    chk("wrap_ch0", last_res_ch, 0);
    run = 1'b0; wait_idle(500);

    // Sparse mask: ch0/ch2 alternate
    ch_enable = 4'b0101; run = 1'b1;
    wait_hs(4, 2000);
    run = 1'b0; wait_idle(500);

    // Channel stuck low -> timeout
    cfg_low[1] = 1; ch_enable = 4'b0011; run = 1'b1;
    wait_hs(2, 2000);
    run = 1'b0; wait_idle(500);
    cfg_low[1] = 0;

    // Single channel, stable-vs-timeout boundary on the last MEASURE cycle
    ch_enable = 4'b1000; cfg_delay[3] = TMO - 2; run = 1'b1;
    wait_hs(2, 1000);
    run = 1'b0; wait_idle(500);
    cfg_delay[3] = TMO - 1; run = 1'b1;
    wait_hs(1, 1000);
    run = 1'b0; wait_idle(500);
    default_cfg();

    // Backpressure: hold ready low for 50 cycles in OUTPUT
    ch_enable = 4'b1111; res_ready = 1'b0; run = 1'b1;
    begin
      int b = 1000;
      while (!res_valid && b > 0) begin tick(); b--; end
    end
    chk("bp_valid_seen", res_valid, 1);
    repeat (50) tick();
    chk("bp_valid_held", res_valid, 1);
    res_ready = 1'b1;
    wait_hs(1, 10);

    // Drop run during MEASURE of ch2
    wait_meas(2, 2000);
    run = 1'b0;
    wait_idle(500);
    tick();
    chk("stop_busy", busy, 0);
    chk("stop_det_clear", det_clear, 1);
    chk("stop_last_ch", last_res_ch, 2);

    // Reset mid-MEASURE, then rescan from ch0
    run = 1'b1;
    wait_meas(-1, 500);
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    wait_hs(1, 500);
    chk("rescan_ch0", last_res_ch, 0);
    run = 1'b0; wait_idle(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
